// File: rtl/abc_sweep_sequencer_pkg.sv
// Shared types, constants and the reference-sum helper for the a/b/c sweep sequencer.
// Optional capture logging is enabled with the ABC_SEQ_CAPTURE_EN macro.
package abc_sweep_sequencer_pkg;

    localparam int NUM_VEC = 8;
    localparam int VEC_W   = 3;
    localparam int ERR_W   = 4;
    localparam int CAP_W   = 2 * NUM_VEC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Two-bit sum that wraps, so 1+1+1 yields 2'b11 and never carries out.
    function automatic logic [1:0] exp_sum(input logic a, input logic b, input logic c);
        logic [1:0] s;
        s = {1'b0, a} + {1'b0, b} + {1'b0, c};
        return s;
    endfunction

endpackage

// File: rtl/abc_sweep_sequencer_if.sv
// Bundle of control, stimulus and result signals between the sequencer and its environment.
// The cap_log signal exists only when ABC_SEQ_CAPTURE_EN is defined.
interface abc_sweep_sequencer_if;
    import abc_sweep_sequencer_pkg::*;

    // start/abort are single-cycle pulses sampled on the rising edge; there is no ready,
    // a start counts as accepted only when busy rises on the following edge.
    logic                start;
    logic                abort;
    logic [1:0]          out;
    logic                a;
    logic                b;
    logic                c;
    logic                busy;
    logic                done;
    logic [ERR_W-1:0]    err_cnt;
    logic [NUM_VEC-1:0]  fail_vec;
    state_t              dbg_state;

`ifdef ABC_SEQ_CAPTURE_EN
    logic [CAP_W-1:0]    cap_log;

    modport slave (
        input  start, abort, out,
        output a, b, c, busy, done, err_cnt, fail_vec, dbg_state, cap_log
    );

    modport master (
        output start, abort, out,
        input  a, b, c, busy, done, err_cnt, fail_vec, dbg_state, cap_log
    );
`else
    modport slave (
        input  start, abort, out,
        output a, b, c, busy, done, err_cnt, fail_vec, dbg_state
    );

    modport master (
        output start, abort, out,
        input  a, b, c, busy, done, err_cnt, fail_vec, dbg_state
    );
`endif

endinterface

// File: rtl/abc_dwell_timer.sv
// Per-code dwell timer: counts cycles a code has been held and flags the sample and
// last-cycle points of the dwell window.
module abc_dwell_timer #(
    parameter int DWELL      = 200,
    parameter int SAMPLE_DLY = 2
) (
    input  logic Clock,
    input  logic Rst_n,
    input  logic clr,
    input  logic en,
    output logic sample_hit,
    output logic dwell_end
);

    localparam int TW = $clog2(DWELL);
    localparam logic [TW-1:0] SAMPLE_AT = TW'(SAMPLE_DLY);
    localparam logic [TW-1:0] LAST_AT   = TW'(DWELL - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    assign sample_hit = en && !clr && (timer_q == SAMPLE_AT);
    assign dwell_end  = en && !clr && (timer_q == LAST_AT);

    always_comb begin
        timer_d = timer_q;
        if (clr) begin
            timer_d = '0;
        end else if (en) begin
            timer_d = dwell_end ? '0 : timer_q + TW'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/abc_sweep_sequencer.sv
// Sweeps {a,b,c} through all eight codes, checks the datapath result against a+b+c mod 4,
// and keeps a per-code fail map; ABC_SEQ_CAPTURE_EN adds a log of every sampled result.
module abc_sweep_sequencer
    import abc_sweep_sequencer_pkg::*;
#(
    parameter int DWELL      = 200,
    parameter int SAMPLE_DLY = 2
) (
    input  logic                  Clock,
    input  logic                  Rst_n,
    abc_sweep_sequencer_if.slave  bus
);

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [VEC_W-1:0]    abc_q, abc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [NUM_VEC-1:0]  fail_vec_q, fail_vec_d;
`ifdef ABC_SEQ_CAPTURE_EN
    logic [CAP_W-1:0]    cap_log_q, cap_log_d;
`endif

    logic timer_en;
    logic sample_hit;
    logic dwell_end;
    logic mismatch;
    logic start_ok;

    // The timer only runs while driving; abort stops it in the same cycle it is seen.
    assign timer_en = (state_q == ST_DRIVE) && !bus.abort;
    assign start_ok = bus.start && !bus.abort && (state_q != ST_DRIVE);
    assign mismatch = (bus.out != exp_sum(abc_q[2], abc_q[1], abc_q[0]));

    abc_dwell_timer #(
        .DWELL      (DWELL),
        .SAMPLE_DLY (SAMPLE_DLY)
    ) u_timer (
        .Clock      (Clock),
        .Rst_n      (Rst_n),
        .clr        (!timer_en),
        .en         (timer_en),
        .sample_hit (sample_hit),
        .dwell_end  (dwell_end)
    );

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        abc_d      = abc_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_cnt_d  = err_cnt_q;
        fail_vec_d = fail_vec_q;
`ifdef ABC_SEQ_CAPTURE_EN
        cap_log_d  = cap_log_q;
`endif

        if (bus.abort) begin
            // Results are left alone so a partial sweep can still be inspected.
            state_d = ST_IDLE;
            vec_d   = '0;
            abc_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state_d    = ST_DRIVE;
                        vec_d      = '0;
                        abc_d      = '0;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        err_cnt_d  = '0;
                        fail_vec_d = '0;
`ifdef ABC_SEQ_CAPTURE_EN
                        cap_log_d  = '0;
`endif
                    end
                end
                ST_DRIVE: begin
                    if (sample_hit) begin
                        if (mismatch) begin
                            fail_vec_d[vec_q] = 1'b1;
                            err_cnt_d         = err_cnt_q + ERR_W'(1);
                        end
`ifdef ABC_SEQ_CAPTURE_EN
                        cap_log_d[{vec_q, 1'b0} +: 2] = bus.out;
`endif
                    end
                    if (dwell_end) begin
                        if (vec_q == VEC_W'(NUM_VEC - 1)) begin
                            state_d = ST_DONE;
                            vec_d   = '0;
                            abc_d   = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            vec_d = vec_q + VEC_W'(1);
                            abc_d = vec_q + VEC_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    abc_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            abc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_vec_q <= '0;
`ifdef ABC_SEQ_CAPTURE_EN
            cap_log_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            abc_q      <= abc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_cnt_q  <= err_cnt_d;
            fail_vec_q <= fail_vec_d;
`ifdef ABC_SEQ_CAPTURE_EN
            cap_log_q  <= cap_log_d;
`endif
        end
    end

    assign bus.a         = abc_q[2];
    assign bus.b         = abc_q[1];
    assign bus.c         = abc_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.fail_vec  = fail_vec_q;
    assign bus.dbg_state = state_q;
`ifdef ABC_SEQ_CAPTURE_EN
    assign bus.cap_log   = cap_log_q;
`endif

endmodule

// File: tb/tb_abc_sweep_sequencer.sv
// Bench for abc_sweep_sequencer: directed sweeps against a registered golden adder with
// selectable per-code corruption; ABC_SEQ_CAPTURE_EN also checks the capture log.
module tb_abc_sweep_sequencer;
    import abc_sweep_sequencer_pkg::*;

    localparam int DWELL      = 4;
    localparam int SAMPLE_DLY = 2;
    localparam int W          = 32;

    logic Clock = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clock = ~Clock;

    abc_sweep_sequencer_if bus ();
    abc_sweep_sequencer_if bus2 ();

    abc_sweep_sequencer #(.DWELL(DWELL), .SAMPLE_DLY(SAMPLE_DLY)) dut (
        .Clock (Clock),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    abc_sweep_sequencer #(.DWELL(200), .SAMPLE_DLY(2)) dut_long (
        .Clock (Clock),
        .Rst_n (Rst_n),
        .bus   (bus2)
    );

    // Golden datapath: one register stage; codes flagged in bad_mask return the inverted sum.
    logic [7:0] bad_mask = 8'h00;
    always @(posedge Clock) begin
        if (bad_mask[{bus.a, bus.b, bus.c}])
            bus.out <= ~exp_sum(bus.a, bus.b, bus.c);
        else
            bus.out <= exp_sum(bus.a, bus.b, bus.c);
        bus2.out <= exp_sum(bus2.a, bus2.b, bus2.c);
    end

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp2_q[$];
    logic [W-1:0] snap_q[$];
`ifdef ABC_SEQ_CAPTURE_EN
    logic [W-1:0] cap_q[$];
`endif

    int   checks   = 0;
    int   errors   = 0;
    logic finished = 1'b0;

    function automatic logic [W-1:0] rec(input int len, input logic dn,
                                         input logic [3:0] err, input logic [7:0] fv);
        logic [15:0] l;
        l = len[15:0];
        return {l, 3'b000, dn, err, fv};
    endfunction

    function automatic logic [W-1:0] snap(input logic [1:0] st, input logic [2:0] abc,
                                          input logic bsy, input logic dn,
                                          input logic [3:0] err, input logic [7:0] fv);
        return {13'd0, st, abc, bsy, dn, err, fv};
    endfunction

    function void check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: per-cycle code tracking, sweep-end records and idle snapshots.
    int   len1  = 0;
    int   len2  = 0;
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;
    always @(negedge Clock) begin
        logic [W-1:0] e;
        logic [W-1:0] g;
        if (bus.busy === 1'b1) begin
            check("code", {29'd0, bus.a, bus.b, bus.c}, W'(len1 / DWELL));
            len1++;
        end else if (prev1) begin
            g = rec(len1, bus.done, bus.err_cnt, bus.fail_vec);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sweep_end unexpected actual=%0h expected=none", g);
            end else begin
                e = exp_q.pop_front();
                check("sweep_end", g, e);
            end
            check("abc_after_sweep", {29'd0, bus.a, bus.b, bus.c}, '0);
            len1 = 0;
        end
        prev1 = (bus.busy === 1'b1);

        if (bus2.busy === 1'b1) begin
            len2++;
        end else if (prev2) begin
            g = rec(len2, bus2.done, bus2.err_cnt, bus2.fail_vec);
            if (exp2_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL long_sweep_end unexpected actual=%0h expected=none", g);
            end else begin
                e = exp2_q.pop_front();
                check("long_sweep_end", g, e);
            end
            len2 = 0;
        end
        prev2 = (bus2.busy === 1'b1);

        if (snap_q.size() != 0) begin
            e = snap_q.pop_front();
            g = snap(bus.dbg_state, {bus.a, bus.b, bus.c}, bus.busy, bus.done,
                     bus.err_cnt, bus.fail_vec);
            check("idle_snapshot", g, e);
        end
`ifdef ABC_SEQ_CAPTURE_EN
        if (cap_q.size() != 0) begin
            e = cap_q.pop_front();
            check("cap_log", {16'd0, bus.cap_log}, e);
        end
`endif

        if (finished) begin
            check("exp_q_drained", W'(exp_q.size()), '0);
            check("exp2_q_drained", W'(exp2_q.size()), '0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic pulse_start();
        @(negedge Clock);
        bus.start = 1'b1;
        @(negedge Clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (bus.busy === 1'b1 && n < max_cycles) begin
            @(negedge Clock);
            n++;
        end
        if (n >= max_cycles) begin
            $display("FAIL wait_idle timeout actual=busy expected=idle within %0d", max_cycles);
            $fatal(1);
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        Rst_n      = 1'b0;
        repeat (3) @(negedge Clock);
        Rst_n = 1'b1;

        // Reset state, and nothing moves without a start.
        repeat (2) @(negedge Clock);
        snap_q.push_back(snap(ST_IDLE, 3'd0, 1'b0, 1'b0, 4'd0, 8'h00));
        repeat (3) @(negedge Clock);
        snap_q.push_back(snap(ST_IDLE, 3'd0, 1'b0, 1'b0, 4'd0, 8'h00));
        @(negedge Clock);

        // Clean sweep.
        exp_q.push_back(rec(32, 1'b1, 4'd0, 8'h00));
        pulse_start();
        wait_idle(100);
`ifdef ABC_SEQ_CAPTURE_EN
        cap_q.push_back(32'h0000_E994);
`endif
        snap_q.push_back(snap(ST_DONE, 3'd0, 1'b0, 1'b1, 4'd0, 8'h00));
        @(negedge Clock);

        // Code 7 returns 2'b00 instead of 2'b11.
        bad_mask = 8'h80;
        exp_q.push_back(rec(32, 1'b1, 4'd1, 8'h80));
        pulse_start();
        wait_idle(100);
        snap_q.push_back(snap(ST_DONE, 3'd0, 1'b0, 1'b1, 4'd1, 8'h80));
        @(negedge Clock);

        // Abort in the 10th busy cycle; code 1 already failed, code 3 never reached.
        bad_mask = 8'h0A;
        exp_q.push_back(rec(10, 1'b0, 4'd1, 8'h02));
        pulse_start();
        repeat (9) @(negedge Clock);
        bus.abort = 1'b1;
        @(negedge Clock);
        bus.abort = 1'b0;
        bad_mask  = 8'h00;
        snap_q.push_back(snap(ST_IDLE, 3'd0, 1'b0, 1'b0, 4'd1, 8'h02));
        repeat (2) @(negedge Clock);
        exp_q.push_back(rec(32, 1'b1, 4'd0, 8'h00));
        pulse_start();
        wait_idle(100);
        @(negedge Clock);

        // start together with abort (from DONE): no sweep, done drops.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge Clock);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        snap_q.push_back(snap(ST_IDLE, 3'd0, 1'b0, 1'b0, 4'd0, 8'h00));
        repeat (2) @(negedge Clock);
        snap_q.push_back(snap(ST_IDLE, 3'd0, 1'b0, 1'b0, 4'd0, 8'h00));
        @(negedge Clock);

        // Second start during cycle 5 of a sweep is ignored.
        exp_q.push_back(rec(32, 1'b1, 4'd0, 8'h00));
        pulse_start();
        repeat (4) @(negedge Clock);
        bus.start = 1'b1;
        @(negedge Clock);
        bus.start = 1'b0;
        wait_idle(100);
        @(negedge Clock);

        // Reset mid-sweep clears the code-0 failure, unlike abort.
        bad_mask = 8'h01;
        exp_q.push_back(rec(8, 1'b0, 4'd0, 8'h00));
        pulse_start();
        repeat (7) @(negedge Clock);
        Rst_n = 1'b0;
        repeat (2) @(negedge Clock);
        Rst_n    = 1'b1;
        bad_mask = 8'h00;
        @(negedge Clock);
        snap_q.push_back(snap(ST_IDLE, 3'd0, 1'b0, 1'b0, 4'd0, 8'h00));
        repeat (2) @(negedge Clock);

        // Long dwell: 8 * 200 busy cycles.
        exp2_q.push_back(rec(1600, 1'b1, 4'd0, 8'h00));
        bus2.start = 1'b1;
        @(negedge Clock);
        bus2.start = 1'b0;
        for (int n = 0; n < 2000 && bus2.busy === 1'b1; n++) @(negedge Clock);
        if (bus2.busy === 1'b1) begin
            $display("FAIL long_sweep timeout actual=busy expected=idle within 2000");
            $fatal(1);
        end
        repeat (3) @(negedge Clock);
        finished = 1'b1;
    end

endmodule
